// File: rtl/fp32_pkg.sv
// Shared constants, FSM state type and operand classification for the FP32 divider.
package fp32_pkg;
  localparam int          EXP_BIAS     = 127;
  localparam logic [7:0]  EXP_MAX      = 8'hff;
  localparam logic [22:0] QNAN_DEFAULT = 23'h400000;
  localparam int          DIV_ITERS    = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_NORM,
    S_DIV,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    FC_ZERO,
    FC_SUB,
    FC_NORM,
    FC_INF,
    FC_NAN
  } fclass_t;

  function automatic fclass_t classify(input logic [30:0] v);
    if (v[30:23] == EXP_MAX) return (v[22:0] == '0) ? FC_INF : FC_NAN;
    if (v[30:23] == 8'h00)   return (v[22:0] == '0) ? FC_ZERO : FC_SUB;
    return FC_NORM;
  endfunction
endpackage

// File: rtl/mant_div_iter.sv
// Radix-2 restoring mantissa divider: one quotient bit per cycle, 25 steps per start.
module mant_div_iter
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [24:0] i_dividend,
  input  logic [23:0] i_divisor,
  output logic [23:0] o_quot,
  output logic        o_done
);
  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  logic        r_busy;
  logic [4:0]  r_cnt;
  logic [25:0] r_rem;
  logic [23:0] r_div;
  logic [23:0] r_quot;
  logic        w_ge;
  logic [25:0] w_rem_sel;

  assign w_ge      = r_rem >= {2'b00, r_div};
  assign w_rem_sel = w_ge ? (r_rem - {2'b00, r_div}) : r_rem;
  assign o_done    = r_busy && (r_cnt == LAST_ITER);
  // The leading integer bit is always 1 and falls off the top of the
  // 24-bit shift register, leaving {fraction[22:0], guard}.
  assign o_quot    = r_quot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_quot <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= {1'b0, i_dividend};
      r_div  <= i_divisor;
      r_quot <= '0;
    end else if (r_busy) begin
      r_rem  <= w_rem_sel << 1;
      r_quot <= {r_quot[22:0], w_ge};
      r_cnt  <= r_cnt + 5'd1;
      if (r_cnt == LAST_ITER) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/fp32_divider.sv
// Sequential IEEE-754 binary32 divider with valid/ready handshakes,
// round-to-nearest ties-away and quiet-NaN propagation.
//   state  | meaning
//   IDLE   | in_ready high, waiting for operands
//   UNPACK | classify operands, resolve special values
//   NORM   | normalize mantissas, form exponent, start the divider
//   DIV    | 25 restoring iterations
//   ROUND  | round, range check and pack
//   DONE   | out_valid high until out_ready
module fp32_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] output_z,
  output logic        exception
);
  state_t             r_state, w_next;
  logic [31:0]        r_a, r_b;
  logic signed [9:0]  r_exp;
  logic [31:0]        r_z;
  logic               r_exc;

  logic               w_sign;
  fclass_t            w_cls_a, w_cls_b;
  logic               w_special, w_spec_exc;
  logic [31:0]        w_spec_z;
  logic [4:0]         w_lz_a, w_lz_b;
  logic [23:0]        w_ma, w_mb;
  logic signed [9:0]  w_ea, w_eb, w_e0, w_e_norm, w_e_rnd;
  logic               w_lt;
  logic [24:0]        w_ma25;
  logic [23:0]        w_quot;
  logic               w_div_done, w_carry;
  logic [22:0]        w_frac;
  logic [31:0]        w_rnd_z;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) if (v[i]) n = 5'(23 - i);
    return n;
  endfunction

  assign w_sign  = r_a[31] ^ r_b[31];
  assign w_cls_a = classify(r_a[30:0]);
  assign w_cls_b = classify(r_b[30:0]);

  // Special-value priority: NaN, invalid, inf dividend, divide-by-zero, zero result.
  always_comb begin
    w_special  = 1'b1;
    w_spec_exc = 1'b0;
    w_spec_z   = {w_sign, 31'd0};
    if (w_cls_a == FC_NAN)
      w_spec_z = {w_sign, EXP_MAX, 1'b1, r_a[21:0]};
    else if (w_cls_b == FC_NAN)
      w_spec_z = {w_sign, EXP_MAX, 1'b1, r_b[21:0]};
    else if ((w_cls_a == FC_ZERO && w_cls_b == FC_ZERO) ||
             (w_cls_a == FC_INF  && w_cls_b == FC_INF))
      w_spec_z = {w_sign, EXP_MAX, QNAN_DEFAULT};
    else if (w_cls_a == FC_INF)
      w_spec_z = {w_sign, EXP_MAX, 23'd0};
    else if (w_cls_b == FC_ZERO) begin
      w_spec_z   = {w_sign, EXP_MAX, 23'd0};
      w_spec_exc = 1'b1;
    end else if (w_cls_a == FC_ZERO || w_cls_b == FC_INF)
      w_spec_z = {w_sign, 31'd0};
    else
      w_special = 1'b0;
  end

  assign w_lz_a = lzc24({1'b0, r_a[22:0]});
  assign w_lz_b = lzc24({1'b0, r_b[22:0]});
  assign w_ma = (w_cls_a == FC_SUB) ? ({1'b0, r_a[22:0]} << w_lz_a) : {1'b1, r_a[22:0]};
  assign w_mb = (w_cls_b == FC_SUB) ? ({1'b0, r_b[22:0]} << w_lz_b) : {1'b1, r_b[22:0]};
  assign w_ea = (w_cls_a == FC_SUB) ? (10'sd1 - $signed({5'd0, w_lz_a}))
                                    : $signed({2'b00, r_a[30:23]});
  assign w_eb = (w_cls_b == FC_SUB) ? (10'sd1 - $signed({5'd0, w_lz_b}))
                                    : $signed({2'b00, r_b[30:23]});
  assign w_e0 = w_ea - w_eb + $signed(10'(EXP_BIAS));
  // Pre-shift the dividend so the quotient always lands in [1,2).
  assign w_lt     = w_ma < w_mb;
  assign w_ma25   = w_lt ? {w_ma, 1'b0} : {1'b0, w_ma};
  assign w_e_norm = w_lt ? (w_e0 - 10'sd1) : w_e0;

  mant_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (r_state == S_NORM),
    .i_dividend(w_ma25),
    .i_divisor (w_mb),
    .o_quot    (w_quot),
    .o_done    (w_div_done)
  );

  // A carry out of the fraction means the mantissa rounded up to 2.0.
  assign {w_carry, w_frac} = {1'b0, w_quot[23:1]} + {23'd0, w_quot[0]};
  assign w_e_rnd = r_exp + $signed({9'd0, w_carry});

  always_comb begin
    if (w_e_rnd >= $signed({2'b00, EXP_MAX}))
      w_rnd_z = {w_sign, EXP_MAX, 23'd0};
    else if (w_e_rnd <= 10'sd0)
      w_rnd_z = {w_sign, 31'd0};
    else
      w_rnd_z = {w_sign, w_e_rnd[7:0], w_frac};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = S_UNPACK;
      S_UNPACK: w_next = w_special ? S_DONE : S_NORM;
      S_NORM:   w_next = S_DIV;
      S_DIV:    if (w_div_done) w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_exp <= '0;
      r_z   <= '0;
      r_exc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= input_a;
          r_b <= input_b;
        end
        S_UNPACK: if (w_special) begin
          r_z   <= w_spec_z;
          r_exc <= w_spec_exc;
        end
        S_NORM:  r_exp <= w_e_norm;
        S_ROUND: begin
          r_z   <= w_rnd_z;
          r_exc <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign output_z  = r_z;
  assign exception = r_exc;
endmodule

// File: tb/tb_fp32_divider.sv
// Directed scoreboard bench for fp32_divider: results, latency, backpressure and reset abort.
module tb_fp32_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] input_a = '0;
  logic [31:0] input_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] output_z;
  logic        exception;

  typedef struct packed {
    logic [31:0] z;
    logic        exc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fp32_divider dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .input_a  (input_a),
    .input_b  (input_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .output_z (output_z),
    .exception(exception)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "simulation did not complete");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] want, input string tag);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ez,
                        input logic ee, input int elat, input int hold, input string tag);
    exp_t e;
    int   n;
    @(negedge clk);
    input_a  = a;
    input_b  = b;
    in_valid = 1'b1;
    sb_q.push_back('{z: ez, exc: ee});
    chk({31'd0, in_ready}, 32'd1, {tag, ".in_ready"});
    @(posedge clk); #1;
    // Keep in_valid high with junk operands while busy: they must be ignored.
    input_a = $urandom;
    input_b = $urandom;
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk(32'(n), 32'(elat), {tag, ".latency"});
    e = sb_q.pop_front();
    for (int k = 0; k < hold; k++) begin
      chk(output_z, e.z, {tag, ".hold_z"});
      chk({31'd0, exception}, {31'd0, e.exc}, {tag, ".hold_exc"});
      chk({30'd0, out_valid, in_ready}, 32'b10, {tag, ".hold_vr"});
      @(posedge clk); #1;
    end
    chk(output_z, e.z, {tag, ".z"});
    chk({31'd0, exception}, {31'd0, e.exc}, {tag, ".exc"});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({30'd0, out_valid, in_ready}, 32'b01, {tag, ".consume"});
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    chk({30'd0, in_ready, out_valid}, 32'b10, "reset.rdy_vld");
    chk(output_z, 32'h0, "reset.z");
    chk({31'd0, exception}, 32'd0, "reset.exc");
    @(negedge clk) rst = 1'b1;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, 10, "six_by_two");
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28, 0, "one_third");
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1, 0, "div_by_zero");
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1, 0, "zero_zero");
    run_op(32'h7F800001, 32'h3F800000, 32'h7FC00001, 1'b0, 1, 0, "nan_a");
    run_op(32'h3F800000, 32'hFFC00123, 32'hFFC00123, 1'b0, 1, 0, "nan_b");
    run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 28, 0, "overflow");
    run_op(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 28, 0, "flush");
    run_op(32'h00400000, 32'h00800000, 32'h3F000000, 1'b0, 28, 0, "sub_dividend");
    run_op(32'h3F800000, 32'h00400000, 32'h7F000000, 1'b0, 28, 0, "sub_divisor");
    run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 28, 0, "neg_six");
    run_op(32'h40E00000, 32'h40000000, 32'h40600000, 1'b0, 28, 0, "seven_by_two");
    run_op(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1, 0, "neg_div_zero");
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1, 0, "inf_inf");
    run_op(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1, 0, "inf_x");
    run_op(32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1, 0, "inf_zero");
    run_op(32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 1, 0, "zero_x");
    run_op(32'h40A00000, 32'hFF800000, 32'h80000000, 1'b0, 1, 0, "x_neg_inf");

    // Abort an operation mid-DIV with reset.
    @(negedge clk);
    input_a  = 32'h40C00000;
    input_b  = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk({30'd0, in_ready, out_valid}, 32'b10, "abort.rdy_vld");
    chk(output_z, 32'h0, "abort.z");
    @(negedge clk) rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    chk(32'(seen), 32'd0, "abort.no_output");
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, 0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
